bdy_but_pwm: RTL and testbench

- Polynomial arithmetic engine for the Ncc-Sign accelerator, sitting between the AXI-Stream read DMA (Rs) and write DMA (Wm).
- Loads operand polynomial A into an internal buffer, then streams in a second operand: B coefficients in PWM mode, twiddles in NTT/INTT modes.
- Each output is computed modulo a selectable prime and streamed back, two coefficients per 64-bit beat.

---
 rtl/bdy_but_pwm_pkg.sv | 39 +++
 rtl/bdy_mod_mul.sv | 56 +++++
 rtl/bdy_but_pwm.sv | 199 +++++++++++++++++++
 tb/tb_bdy_but_pwm.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bdy_but_pwm_pkg.sv
// Shared encodings and constants for the polynomial butterfly / pointwise-multiply engine.
package bdy_but_pwm_pkg;

  typedef enum logic [1:0] {
    BUT_PWM  = 2'd0,
    BUT_NTT  = 2'd1,
    BUT_INTT = 2'd2
  } but_e;

  typedef enum logic {
    QSEL_Q1 = 1'b0,
    QSEL_Q2 = 1'b1
  } qsel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMP,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int PIPE_LAT = 4;

  // Encoding 3 is an alias for pointwise multiply.
  function automatic but_e decode_but(input logic [1:0] ctl);
    case (ctl)
      2'd1:    return BUT_NTT;
      2'd2:    return BUT_INTT;
      default: return BUT_PWM;
    endcase
  endfunction

  // Only select value 1 picks the second prime.
  function automatic qsel_e decode_q(input logic [1:0] ctl);
    return (ctl == 2'd1) ? QSEL_Q2 : QSEL_Q1;
  endfunction

endpackage

// File: rtl/bdy_mod_mul.sv
// Pipelined modular multiplier: r = (a*b) mod q, three register stages, stallable.
module bdy_mod_mul #(
  parameter int PRM_DRAM = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                vld_i,
  input  logic [PRM_DRAM-1:0] a_i,
  input  logic [PRM_DRAM-1:0] b_i,
  input  logic [PRM_DRAM-1:0] q_i,
  output logic                vld_o,
  output logic [PRM_DRAM-1:0] r_o
);

  localparam int PW = 2 * PRM_DRAM;

  logic [PRM_DRAM-1:0] a_p0_q, b_p0_q, q_p0_q, q_p1_q, r_p2_q;
  logic [PW-1:0]       prod_p1_q;
  logic                vld_p0_q, vld_p1_q, vld_p2_q;

  function automatic logic [PRM_DRAM-1:0] reduce_mod(input logic [PW-1:0] p,
                                                     input logic [PRM_DRAM-1:0] q);
    return PRM_DRAM'(p % PW'(q));
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (en_i) begin
      vld_p0_q <= vld_i;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      // p0: operand capture
      a_p0_q    <= a_i;
      b_p0_q    <= b_i;
      q_p0_q    <= q_i;
      // p1: full-width product
      prod_p1_q <= PW'(a_p0_q) * PW'(b_p0_q);
      q_p1_q    <= q_p0_q;
      // p2: exact reduction
      r_p2_q    <= reduce_mod(prod_p1_q, q_p1_q);
    end
  end

  assign vld_o = vld_p2_q;
  assign r_o   = r_p2_q;

endmodule

// File: rtl/bdy_but_pwm.sv
// Polynomial engine: buffers operand A, then streams B (PWM) or twiddles (NTT/INTT)
// through a modular multiplier and a final add/sub stage, two coefficients per beat.
module bdy_but_pwm
  import bdy_but_pwm_pkg::*;
#(
  parameter int          PRM_DAXI   = 64,
  parameter int          PRM_ADDR   = 12,
  parameter int          PRM_DRAM   = 32,
  parameter int          PRM_COEFFS = 64,
  parameter int unsigned PRM_Q1     = 32'd8380417,
  parameter int unsigned PRM_Q2     = 32'd8816641
) (
  input  logic                iSYS_CLK,
  input  logic                iSYS_RST,
  input  logic                iFSM_START,
  input  logic [1:0]          iCTL_BUT,
  input  logic [1:0]          iCTL_Q,
  output logic                oFSM_DONE,
  input  logic                iRs_Tvalid,
  output logic                oRs_Tready,
  input  logic [PRM_DAXI-1:0] iRs_Tdata,
  input  logic                iRs_Tlast,
  output logic                oWm_Tvalid,
  input  logic                iWm_Tready,
  output logic [PRM_DAXI-1:0] oWm_Tdata,
  output logic                oWm_Tlast
);

  localparam int            AW        = $clog2(PRM_COEFFS);
  localparam int            CW        = PRM_ADDR + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(PRM_COEFFS / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(PRM_COEFFS - 1);

  state_e              state_q, state_d;
  but_e                mode_q;
  qsel_e               qsel_q;
  logic [CW-1:0]       in_cnt_q, out_cnt_q, comp_last;
  logic [PRM_DRAM-1:0] abuf_q [PRM_COEFFS];
  logic [PRM_DRAM-1:0] q_val, pwm_a, u_in, v_in, mul_a, side_in, side_o, mul_r, lo_q;
  logic [PRM_DRAM-1:0] side_q [PIPE_LAT-1];
  logic [PRM_DAXI-1:0] word, wm_data_q;
  logic                stall, rs_ready, rs_acc, done, mul_vld, word_vld;
  logic                wm_vld_q, wm_last_q, pwm_odd_q;
  logic                unused_tlast;

  function automatic logic [PRM_DRAM-1:0] add_mod(input logic [PRM_DRAM-1:0] x, y, q);
    return ((x + y) >= q) ? (x + y - q) : (x + y);
  endfunction

  function automatic logic [PRM_DRAM-1:0] sub_mod(input logic [PRM_DRAM-1:0] x, y, q);
    return (x >= y) ? (x - y) : (x + (q - y));
  endfunction

  // Phase lengths are purely count-based, so the stream's last flag carries no meaning here.
  assign unused_tlast = iRs_Tlast;

  assign q_val     = (qsel_q == QSEL_Q2) ? PRM_DRAM'(PRM_Q2) : PRM_DRAM'(PRM_Q1);
  assign stall     = wm_vld_q && !iWm_Tready;
  assign rs_acc    = iRs_Tvalid && rs_ready;
  assign comp_last = (mode_q == BUT_PWM) ? FULL_LAST : HALF_LAST;

  always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
    if (iSYS_RST) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (iFSM_START) state_d = ST_LOAD;
      ST_LOAD:  if (rs_acc && in_cnt_q == HALF_LAST) state_d = ST_COMP;
      ST_COMP:  if (rs_acc && in_cnt_q == comp_last) state_d = ST_DRAIN;
      ST_DRAIN: if (wm_vld_q && iWm_Tready && wm_last_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rs_ready = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_LOAD: rs_ready = 1'b1;
      ST_COMP: rs_ready = !stall;
      ST_DONE: done     = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
    if (iSYS_RST) begin
      in_cnt_q <= '0;
      mode_q   <= BUT_PWM;
      qsel_q   <= QSEL_Q1;
    end else begin
      if (state_q != state_d) in_cnt_q <= '0;
      else if (rs_acc)        in_cnt_q <= in_cnt_q + 1'b1;
      if (state_q == ST_IDLE && iFSM_START) begin
        mode_q <= decode_but(iCTL_BUT);
        qsel_q <= decode_q(iCTL_Q);
      end
    end
  end

  always_ff @(posedge iSYS_CLK) begin
    if (state_q == ST_LOAD && rs_acc) begin
      abuf_q[{in_cnt_q[AW-2:0], 1'b0}] <= iRs_Tdata[PRM_DRAM-1:0];
      abuf_q[{in_cnt_q[AW-2:0], 1'b1}] <= iRs_Tdata[PRM_DAXI-1:PRM_DRAM];
    end
  end

  assign pwm_a = abuf_q[in_cnt_q[AW-1:0]];
  assign u_in  = abuf_q[{in_cnt_q[AW-2:0], 1'b0}];
  assign v_in  = abuf_q[{in_cnt_q[AW-2:0], 1'b1}];

  // INTT pre-combines the pair so the multiplier sees (u-v) and u+v rides alongside.
  always_comb begin
    mul_a   = pwm_a;
    side_in = u_in;
    unique case (mode_q)
      BUT_NTT:  mul_a = v_in;
      BUT_INTT: begin
        mul_a   = sub_mod(u_in, v_in, q_val);
        side_in = add_mod(u_in, v_in, q_val);
      end
      default: ;
    endcase
  end

  bdy_mod_mul #(.PRM_DRAM(PRM_DRAM)) u_mul (
    .clk_i (iSYS_CLK),
    .rst_i (iSYS_RST),
    .en_i  (!stall),
    .vld_i (rs_acc && state_q == ST_COMP),
    .a_i   (mul_a),
    .b_i   (iRs_Tdata[PRM_DRAM-1:0]),
    .q_i   (q_val),
    .vld_o (mul_vld),
    .r_o   (mul_r)
  );

  always_ff @(posedge iSYS_CLK) begin
    if (!stall) begin
      side_q[0] <= side_in;
      for (int i = 1; i < PIPE_LAT - 1; i++) side_q[i] <= side_q[i-1];
    end
  end

  assign side_o = side_q[PIPE_LAT-2];

  // p3: butterfly combine / PWM pairing into one output word
  always_comb begin
    word_vld = 1'b0;
    word     = {mul_r, lo_q};
    unique case (mode_q)
      BUT_NTT: begin
        word_vld = mul_vld;
        word     = {sub_mod(side_o, mul_r, q_val), add_mod(side_o, mul_r, q_val)};
      end
      BUT_INTT: begin
        word_vld = mul_vld;
        word     = {mul_r, side_o};
      end
      default: word_vld = mul_vld && pwm_odd_q;
    endcase
  end

  always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
    if (iSYS_RST) begin
      wm_vld_q  <= 1'b0;
      wm_data_q <= '0;
      wm_last_q <= 1'b0;
      out_cnt_q <= '0;
      pwm_odd_q <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      out_cnt_q <= '0;
      pwm_odd_q <= 1'b0;
    end else if (!stall) begin
      wm_vld_q  <= word_vld;
      wm_last_q <= word_vld && (out_cnt_q == HALF_LAST);
      if (word_vld) begin
        wm_data_q <= word;
        out_cnt_q <= out_cnt_q + 1'b1;
      end
      if (mul_vld && mode_q == BUT_PWM) pwm_odd_q <= !pwm_odd_q;
    end
  end

  always_ff @(posedge iSYS_CLK) begin
    if (!stall && mul_vld && mode_q == BUT_PWM && !pwm_odd_q) lo_q <= mul_r;
  end

  assign oRs_Tready = rs_ready;
  assign oFSM_DONE  = done;
  assign oWm_Tvalid = wm_vld_q;
  assign oWm_Tdata  = wm_data_q;
  assign oWm_Tlast  = wm_last_q;

endmodule

// File: tb/tb_bdy_but_pwm.sv
// Randomized self-checking bench for bdy_but_pwm against an arithmetic reference model.
module tb_bdy_but_pwm;

  localparam int          NC = 64;
  localparam int          NH = 32;
  localparam longint unsigned Q1 = 64'd8380417;
  localparam longint unsigned Q2 = 64'd8816641;

  logic        clk = 1'b0;
  logic        rst;
  logic        iFSM_START;
  logic [1:0]  iCTL_BUT, iCTL_Q;
  logic        oFSM_DONE;
  logic        iRs_Tvalid, oRs_Tready, iRs_Tlast;
  logic [63:0] iRs_Tdata;
  logic        oWm_Tvalid, iWm_Tready, oWm_Tlast;
  logic [63:0] oWm_Tdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] stim [256];
  logic        stim_last [256];
  logic [63:0] got_data [256];
  logic        got_last [256];
  logic [63:0] exp_data [128];
  int          got_n, exp_n, dcnt, rdy_viol, stab_viol;
  bit          timeout;

  always #5 clk = ~clk;

  bdy_but_pwm dut (
    .iSYS_CLK   (clk),
    .iSYS_RST   (rst),
    .iFSM_START (iFSM_START),
    .iCTL_BUT   (iCTL_BUT),
    .iCTL_Q     (iCTL_Q),
    .oFSM_DONE  (oFSM_DONE),
    .iRs_Tvalid (iRs_Tvalid),
    .oRs_Tready (oRs_Tready),
    .iRs_Tdata  (iRs_Tdata),
    .iRs_Tlast  (iRs_Tlast),
    .oWm_Tvalid (oWm_Tvalid),
    .iWm_Tready (iWm_Tready),
    .oWm_Tdata  (oWm_Tdata),
    .oWm_Tlast  (oWm_Tlast)
  );

  function automatic bit is_bfly(input logic [1:0] but);
    return (but == 2'd1) || (but == 2'd2);
  endfunction

  function automatic longint unsigned qof(input logic [1:0] qs);
    return (qs == 2'd1) ? Q2 : Q1;
  endfunction

  // Reference model: polynomial-level arithmetic on the stimulus table.
  task automatic build_expected(input logic [1:0] but, input logic [1:0] qs, input int njobs);
    longint unsigned q, u, v, w, t, lo, hi;
    longint unsigned a [NC];
    int nin, base;
    q = qof(qs);
    nin = NH + (is_bfly(but) ? NH : NC);
    exp_n = 0;
    for (int job = 0; job < njobs; job++) begin
      base = job * nin;
      for (int k = 0; k < NH; k++) begin
        a[2*k]   = stim[base+k][31:0];
        a[2*k+1] = stim[base+k][63:32];
      end
      for (int j = 0; j < NH; j++) begin
        u = a[2*j];
        v = a[2*j+1];
        if (!is_bfly(but)) begin
          lo = (u * stim[base+NH+2*j][31:0]) % q;
          hi = (v * stim[base+NH+2*j+1][31:0]) % q;
        end else begin
          w = stim[base+NH+j][31:0];
          if (but == 2'd1) begin
            t  = (w * v) % q;
            lo = (u + t) % q;
            hi = (u + q - t) % q;
          end else begin
            lo = (u + v) % q;
            hi = (((u + q - v) % q) * w) % q;
          end
        end
        exp_data[exp_n] = {hi[31:0], lo[31:0]};
        exp_n++;
      end
    end
  endtask

  task automatic fill_random(input int njobs, input logic [1:0] but, input logic [1:0] qs);
    longint unsigned q;
    int nin;
    q = qof(qs);
    nin = NH + (is_bfly(but) ? NH : NC);
    for (int i = 0; i < njobs * nin; i++) begin
      stim[i] = {32'($urandom % q), 32'($urandom % q)};
      if ((i % nin) >= NH) stim[i][63:32] = $urandom;
      stim_last[i] = ($urandom_range(0, 7) == 0);
    end
  endtask

  // Drives njobs back-to-back jobs from the stimulus table and records every output beat.
  task automatic run_job(input logic [1:0] but, input logic [1:0] qs, input int njobs,
                         input int rdy_mode, input bit gaps);
    int total_in, in_idx, cyc;
    bit prev_stall;
    logic [63:0] prev_data;
    logic prev_last;
    total_in = njobs * (NH + (is_bfly(but) ? NH : NC));
    got_n = 0; in_idx = 0; cyc = 0; dcnt = 0; rdy_viol = 0; stab_viol = 0; timeout = 0;
    prev_stall = 0; prev_data = '0; prev_last = 0;
    for (int i = 0; i < 256; i++) begin got_data[i] = '0; got_last[i] = 0; end
    @(negedge clk);
    iCTL_BUT = but; iCTL_Q = qs; iFSM_START = 1'b1;
    iRs_Tvalid = 1'b0; iWm_Tready = 1'b1;
    while (dcnt < njobs && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (njobs == 1) begin
        iFSM_START = 1'b0;
        iCTL_BUT = 2'($urandom);
        iCTL_Q   = 2'($urandom);
      end
      case (rdy_mode)
        0:       iWm_Tready = 1'b1;
        1:       iWm_Tready = ((cyc / 3) % 2) == 0;
        default: iWm_Tready = 1'($urandom_range(0, 1));
      endcase
      if (in_idx < total_in) begin
        iRs_Tvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        iRs_Tdata  = stim[in_idx];
        iRs_Tlast  = stim_last[in_idx];
      end else begin
        iRs_Tvalid = 1'b0;
      end
      #1;
      if (prev_stall && (!oWm_Tvalid || oWm_Tdata !== prev_data || oWm_Tlast !== prev_last))
        stab_viol++;
      prev_stall = oWm_Tvalid && !iWm_Tready;
      prev_data  = oWm_Tdata;
      prev_last  = oWm_Tlast;
      if (oWm_Tvalid && iWm_Tready && got_n < 256) begin
        got_data[got_n] = oWm_Tdata;
        got_last[got_n] = oWm_Tlast;
        got_n++;
      end
      if (oWm_Tvalid && !iWm_Tready && oRs_Tready) rdy_viol++;
      if (iRs_Tvalid && oRs_Tready) in_idx++;
      if (oFSM_DONE) dcnt++;
    end
    iFSM_START = 1'b0; iRs_Tvalid = 1'b0; iWm_Tready = 1'b1;
    if (cyc >= 4000) timeout = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (oWm_Tvalid && got_n < 256) got_n++;
      if (oFSM_DONE) dcnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iFSM_START = 0; iCTL_BUT = 0; iCTL_Q = 0;
    iRs_Tvalid = 0; iRs_Tdata = '0; iRs_Tlast = 0; iWm_Tready = 1;
    repeat (3) @(negedge clk);
    checks++; if (oWm_Tvalid !== 1'b0) begin errors++; $display("FAIL rst_wm_valid got %b exp 0", oWm_Tvalid); end
    checks++; if (oWm_Tdata !== 64'd0) begin errors++; $display("FAIL rst_wm_data got %h exp 0", oWm_Tdata); end
    checks++; if (oWm_Tlast !== 1'b0) begin errors++; $display("FAIL rst_wm_last got %b exp 0", oWm_Tlast); end
    checks++; if (oRs_Tready !== 1'b0) begin errors++; $display("FAIL rst_rs_ready got %b exp 0", oRs_Tready); end
    checks++; if (oFSM_DONE !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", oFSM_DONE); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (oRs_Tready !== 1'b0) begin errors++; $display("FAIL idle_rs_ready got %b exp 0", oRs_Tready); end
  endtask

  task automatic fill_pwm_pattern();
    for (int k = 0; k < NH; k++) begin
      stim[k] = {32'(k + 1), 32'(k + 1)};
      stim_last[k] = 0;
    end
    for (int i = 0; i < NC; i++) begin
      stim[NH+i] = {32'($urandom), 32'(33 + i)};
      stim_last[NH+i] = (i == NC - 1);
    end
  endtask

  task automatic test_pwm_basic(input int rdy_mode, input string tag);
    fill_pwm_pattern();
    build_expected(2'd0, 2'd0, 1);
    run_job(2'd0, 2'd0, 1, rdy_mode, 0);
    checks++; if (timeout) begin errors++; $display("FAIL %s_timeout got timeout exp done", tag); end
    checks++; if (got_n !== NH) begin errors++; $display("FAIL %s_count got %0d exp %0d", tag, got_n, NH); end
    checks++; if (got_data[0] !== {32'd34, 32'd33}) begin errors++; $display("FAIL %s_first got %h exp %h", tag, got_data[0], {32'd34, 32'd33}); end
    checks++; if (got_data[1] !== {32'd72, 32'd70}) begin errors++; $display("FAIL %s_second got %h exp %h", tag, got_data[1], {32'd72, 32'd70}); end
    checks++; if (got_data[31] !== {32'd3072, 32'd3040} || got_last[31] !== 1'b1) begin
      errors++; $display("FAIL %s_final got %h/%b exp %h/1", tag, got_data[31], got_last[31], {32'd3072, 32'd3040}); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== ((i % NH) == NH - 1)) begin
        errors++; $display("FAIL %s_beat[%0d] got %h/%b exp %h/%b", tag, i, got_data[i], got_last[i], exp_data[i], (i % NH) == NH - 1); end
    end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL %s_done got %0d pulses exp 1", tag, dcnt); end
    checks++; if (rdy_viol !== 0) begin errors++; $display("FAIL %s_ready_in_stall got %0d exp 0", tag, rdy_viol); end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL %s_stall_stable got %0d exp 0", tag, stab_viol); end
    checks++; if (oRs_Tready !== 1'b0) begin errors++; $display("FAIL %s_idle_after got %b exp 0", tag, oRs_Tready); end
  endtask

  task automatic test_ntt();
    fill_random(1, 2'd1, 2'd0);
    stim[0] = {32'd1, 32'd1};
    stim[NH][31:0] = 32'd33;
    build_expected(2'd1, 2'd0, 1);
    run_job(2'd1, 2'd0, 1, 0, 1);
    checks++; if (timeout || got_n !== NH) begin errors++; $display("FAIL ntt_count got %0d exp %0d", got_n, NH); end
    checks++; if (got_data[0] !== {32'd8380385, 32'd34}) begin errors++; $display("FAIL ntt_first got %h exp %h", got_data[0], {32'd8380385, 32'd34}); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== (i == NH - 1)) begin
        errors++; $display("FAIL ntt_beat[%0d] got %h/%b exp %h", i, got_data[i], got_last[i], exp_data[i]); end
    end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL ntt_done got %0d exp 1", dcnt); end
  endtask

  task automatic test_intt();
    fill_random(1, 2'd2, 2'd1);
    stim[0] = {32'd2, 32'd5};
    stim[1] = {32'd5, 32'd2};
    stim[NH][31:0]   = 32'd3;
    stim[NH+1][31:0] = 32'd1;
    build_expected(2'd2, 2'd1, 1);
    run_job(2'd2, 2'd1, 1, 2, 1);
    checks++; if (timeout || got_n !== NH) begin errors++; $display("FAIL intt_count got %0d exp %0d", got_n, NH); end
    checks++; if (got_data[0] !== {32'd9, 32'd7}) begin errors++; $display("FAIL intt_first got %h exp %h", got_data[0], {32'd9, 32'd7}); end
    checks++; if (got_data[1] !== {32'd8816638, 32'd7}) begin errors++; $display("FAIL intt_second got %h exp %h", got_data[1], {32'd8816638, 32'd7}); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== (i == NH - 1)) begin
        errors++; $display("FAIL intt_beat[%0d] got %h/%b exp %h", i, got_data[i], got_last[i], exp_data[i]); end
    end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL intt_done got %0d exp 1", dcnt); end
  endtask

  task automatic test_random_modes();
    logic [1:0] buts [4];
    logic [1:0] qss [4];
    buts = '{2'd3, 2'd1, 2'd2, 2'd0};
    qss  = '{2'd2, 2'd3, 2'd1, 2'd1};
    for (int t = 0; t < 4; t++) begin
      fill_random(1, buts[t], qss[t]);
      build_expected(buts[t], qss[t], 1);
      run_job(buts[t], qss[t], 1, 2, 1);
      checks++; if (timeout || got_n !== NH) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", t, got_n, NH); end
      for (int i = 0; i < exp_n; i++) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_last[i] !== (i == NH - 1)) begin
          errors++; $display("FAIL rand%0d_beat[%0d] got %h/%b exp %h", t, i, got_data[i], got_last[i], exp_data[i]); end
      end
      checks++; if (dcnt !== 1) begin errors++; $display("FAIL rand%0d_done got %0d exp 1", t, dcnt); end
      checks++; if (rdy_viol !== 0 || stab_viol !== 0) begin errors++; $display("FAIL rand%0d_stall got %0d/%0d exp 0/0", t, rdy_viol, stab_viol); end
    end
  endtask

  task automatic test_reset_mid();
    int cnt, dmid;
    bit seen_out;
    fill_random(1, 2'd0, 2'd0);
    cnt = 0; seen_out = 0; dmid = 0;
    @(negedge clk);
    iCTL_BUT = 2'd0; iCTL_Q = 2'd0; iFSM_START = 1'b1;
    for (int c = 0; c < 400 && cnt < NH + 20; c++) begin
      @(negedge clk);
      iFSM_START = 1'b0; iWm_Tready = 1'b1; iRs_Tvalid = 1'b1; iRs_Tdata = stim[cnt]; iRs_Tlast = 0;
      #1;
      if (oWm_Tvalid) seen_out = 1;
      if (oRs_Tready) cnt++;
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (!seen_out) begin errors++; $display("FAIL midrst_outputs_started got 0 exp 1"); end
    checks++; if ({oWm_Tvalid, oWm_Tlast, oRs_Tready, oFSM_DONE} !== 4'b0 || oWm_Tdata !== 64'd0) begin
      errors++; $display("FAIL midrst_outputs got v%b l%b r%b d%b data %h exp all 0", oWm_Tvalid, oWm_Tlast, oRs_Tready, oFSM_DONE, oWm_Tdata); end
    iRs_Tvalid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (oFSM_DONE || oWm_Tvalid) dmid++;
    end
    checks++; if (dmid !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", dmid); end
    fill_random(1, 2'd0, 2'd0);
    build_expected(2'd0, 2'd0, 1);
    run_job(2'd0, 2'd0, 1, 1, 1);
    checks++; if (timeout || got_n !== NH || dcnt !== 1) begin
      errors++; $display("FAIL midrst_rerun got %0d beats %0d done exp %0d beats 1 done", got_n, dcnt, NH); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (got_data[i] !== exp_data[i]) begin
        errors++; $display("FAIL midrst_beat[%0d] got %h exp %h", i, got_data[i], exp_data[i]); end
    end
  endtask

  task automatic test_start_held();
    fill_random(2, 2'd0, 2'd1);
    build_expected(2'd0, 2'd1, 2);
    run_job(2'd0, 2'd1, 2, 2, 1);
    checks++; if (timeout) begin errors++; $display("FAIL held_timeout got timeout exp 2 jobs"); end
    checks++; if (dcnt !== 2) begin errors++; $display("FAIL held_done got %0d exp 2", dcnt); end
    checks++; if (got_n !== 2 * NH) begin errors++; $display("FAIL held_count got %0d exp %0d", got_n, 2 * NH); end
    for (int i = 0; i < exp_n; i++) begin
      checks++;
      if (got_data[i] !== exp_data[i] || got_last[i] !== ((i % NH) == NH - 1)) begin
        errors++; $display("FAIL held_beat[%0d] got %h/%b exp %h", i, got_data[i], got_last[i], exp_data[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_pwm_basic(0, "pwm");
    test_pwm_basic(1, "bp");
    test_ntt();
    test_intt();
    test_random_modes();
    test_reset_mid();
    test_start_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
